// File: rtl/arbiter8way16.sv
// Eight-requester round-robin arbiter feeding one 16-bit word path into a
// single-entry valid/ready output register.

module mux8way16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [15:0] e,
    input  logic [15:0] f,
    input  logic [15:0] g,
    input  logic [15:0] h,
    input  logic [2:0]  sel,
    output logic [15:0] out
);
    always_comb begin
        out = a;
        case (sel)
            3'd0: out = a;
            3'd1: out = b;
            3'd2: out = c;
            3'd3: out = d;
            3'd4: out = e;
            3'd5: out = f;
            3'd6: out = g;
            3'd7: out = h;
            default: out = a;
        endcase
    end
endmodule

// Handshake: a word moves to the consumer on an edge where out_valid && out_ready;
// requester i hands over its word on an edge where ack[i] is high.
module arbiter8way16 (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  req,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [15:0] e,
    input  logic [15:0] f,
    input  logic [15:0] g,
    input  logic [15:0] h,
    output logic [7:0]  ack,
    output logic [15:0] out,
    output logic [2:0]  out_src,
    output logic        out_valid,
    input  logic        out_ready
);
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e      state_q;
    logic [15:0] out_q;
    logic [2:0]  src_q;
    logic [2:0]  ptr_q;
    logic [2:0]  ptr_d;
    logic [2:0]  win;
    logic [2:0]  idx;
    logic        found;
    logic [15:0] mux_out;
    logic        load;
    logic        capture;

    // Scan from ptr upward with 3-bit wrap; first asserted request wins.
    always_comb begin
        win   = ptr_q;
        idx   = ptr_q;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = ptr_q + 3'(k);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    mux8way16 u_mux (
        .a   (a),
        .b   (b),
        .c   (c),
        .d   (d),
        .e   (e),
        .f   (f),
        .g   (g),
        .h   (h),
        .sel (win),
        .out (mux_out)
    );

    assign load    = (state_q == EMPTY) || out_ready;
    assign capture = load && found && !reset;
    assign ptr_d   = win + 3'd1;
    assign ack     = capture ? (8'd1 << win) : 8'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            out_q   <= 16'd0;
            src_q   <= 3'd0;
            ptr_q   <= 3'd0;
        end else begin
            if (capture) begin
                out_q <= mux_out;
                src_q <= win;
                ptr_q <= ptr_d;
            end
            case (state_q)
                EMPTY: if (capture) state_q <= FULL;
                FULL:  if (out_ready && !capture) state_q <= EMPTY;
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign out       = out_q;
    assign out_src   = src_q;
    assign out_valid = (state_q == FULL);
endmodule
